clk_div_ctrl: RTL and testbench

- Runtime-programmable clock-divider controller for the SDRAM subsystem.
- Generates a divided clock-enable pulse and a divided-clock level from a single system clock, with no glitches.
- Sequences ratio changes through a request/ack handshake: drain the current period, gate the outputs, load the new ratio, settle, then re-enable and flag lock.
- Sits between the config/CSR logic and the clock consumers (SDRAM timing and refresh logic).

---
 rtl/clk_div_ctrl.sv | 165 ++++++++++++++++
 tb/tb_clk_div_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_ctrl
// Description : Runtime-programmable clock divider for the SDRAM subsystem.
//               Produces a one-cycle enable pulse per divided period and a
//               divided-clock level. Ratio changes go through a handshake:
//               drain the running period, gate the outputs, load the new
//               ratio, settle, then re-enable with lock and ack.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_ctrl #(
    parameter int CNT_W    = 8,
    parameter int DIV_INIT = 2,
    parameter int SETTLE   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cfg_req,
    input  logic [CNT_W-1:0] i_cfg_div,
    output logic             o_cfg_ack,
    output logic             o_cfg_err,
    output logic             o_clk_en,
    output logic             o_clk_div,
    output logic             o_locked,
    output logic             o_busy
);

    localparam int                 c_SET_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_SET_W-1:0] c_SETTLE_LAST = c_SET_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]   c_DIV_INIT    = CNT_W'(DIV_INIT);
    localparam logic [CNT_W-1:0]   c_ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0]   c_MIN_DIV     = CNT_W'(2);

    localparam logic [1:0] c_ST_RUN    = 2'd0;
    localparam logic [1:0] c_ST_DRAIN  = 2'd1;
    localparam logic [1:0] c_ST_LOAD   = 2'd2;
    localparam logic [1:0] c_ST_SETTLE = 2'd3;

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_div;
    logic [CNT_W-1:0]   r_shadow;
    logic [CNT_W-1:0]   r_cnt;
    logic [c_SET_W-1:0] r_settle_cnt;
    logic               r_ack_pend;   // current sequence was started by a request
    logic               r_armed;      // request level has dropped since the last ack
    logic               r_cfg_ack;
    logic               r_cfg_err;
    logic               r_clk_en;
    logic               r_clk_div;
    logic               r_locked;
    logic               r_busy;

    logic [CNT_W-1:0]   w_div_m1;
    logic               w_cnt_last;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_en_nxt;
    logic               w_lvl_nxt;
    logic               w_req_take;
    logic               w_req_bad;

    // Outputs are driven straight from the flops so they are glitch-free.
    assign w_div_m1   = r_div - c_ONE;
    assign w_cnt_last = (r_cnt == w_div_m1);
    assign w_cnt_nxt  = w_cnt_last ? '0 : (r_cnt + c_ONE);
    assign w_en_nxt   = (w_cnt_nxt == w_div_m1);
    assign w_lvl_nxt  = (w_cnt_nxt < (r_div >> 1));
    // A level held past its ack is not re-accepted until it has dropped.
    assign w_req_take = i_cfg_req & r_armed;
    assign w_req_bad  = (i_cfg_div < c_MIN_DIV);

    assign o_cfg_ack  = r_cfg_ack;
    assign o_cfg_err  = r_cfg_err;
    assign o_clk_en   = r_clk_en;
    assign o_clk_div  = r_clk_div;
    assign o_locked   = r_locked;
    assign o_busy     = r_busy;

    // Divider counter, reconfiguration sequencer and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= c_ST_SETTLE;
            r_div        <= c_DIV_INIT;
            r_shadow     <= c_DIV_INIT;
            r_cnt        <= '0;
            r_settle_cnt <= '0;
            r_ack_pend   <= 1'b0;
            r_armed      <= 1'b1;
            r_cfg_ack    <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_clk_en     <= 1'b0;
            r_clk_div    <= 1'b0;
            r_locked     <= 1'b0;
            r_busy       <= 1'b1;
        end else begin
            r_cfg_ack <= 1'b0;
            r_cfg_err <= 1'b0;
            if (!i_cfg_req) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                c_ST_RUN: begin
                    r_cnt     <= w_cnt_nxt;
                    r_clk_en  <= w_en_nxt;
                    r_clk_div <= w_lvl_nxt;
                    if (w_req_take) begin
                        r_armed <= 1'b0;
                        if (w_req_bad) begin
                            // Rejected ratio: ack with error, divider untouched.
                            r_cfg_ack <= 1'b1;
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_shadow   <= i_cfg_div;
                            r_ack_pend <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= c_ST_DRAIN;
                        end
                    end
                end
                c_ST_DRAIN: begin
                    if (w_cnt_last) begin
                        // Final pulse of the old period is out; gate for LOAD.
                        r_cnt     <= '0;
                        r_clk_en  <= 1'b0;
                        r_clk_div <= 1'b0;
                        r_locked  <= 1'b0;
                        r_state   <= c_ST_LOAD;
                    end else begin
                        r_cnt     <= w_cnt_nxt;
                        r_clk_en  <= w_en_nxt;
                        r_clk_div <= w_lvl_nxt;
                    end
                end
                c_ST_LOAD: begin
                    r_div        <= r_shadow;
                    r_cnt        <= '0;
                    r_settle_cnt <= '0;
                    r_state      <= c_ST_SETTLE;
                end
                c_ST_SETTLE: begin
                    if (r_settle_cnt == c_SETTLE_LAST) begin
                        // First RUN cycle sits at cnt 0, i.e. in the high phase.
                        r_cnt     <= '0;
                        r_clk_en  <= 1'b0;
                        r_clk_div <= ((r_div >> 1) != '0);
                        r_locked  <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= c_ST_RUN;
                        if (r_ack_pend) begin
                            r_cfg_ack  <= 1'b1;
                            r_ack_pend <= 1'b0;
                            r_armed    <= 1'b0;
                        end
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_SETTLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_ctrl
// Description : Self-checking bench for clk_div_ctrl. Each driven cycle
//               pushes the expected output vector
//               {clk_en, clk_div, locked, busy, cfg_ack, cfg_err} to a queue;
//               a monitor pops and compares it on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_ctrl;

    localparam int           c_CNT_W  = 8;
    localparam int           c_DIV0   = 2;
    localparam int           c_SETTLE = 4;
    localparam logic [5:0]   c_GATED  = 6'b000100;   // gated, busy, unlocked

    logic             clk;
    logic             rst_n;
    logic             cfg_req;
    logic [7:0]       cfg_div;
    logic             cfg_ack;
    logic             cfg_err;
    logic             clk_en;
    logic             clk_div;
    logic             locked;
    logic             busy;

    int               total;
    int               bad;
    int               m_cnt;
    int               m_div;
    logic [5:0]       exp_q[$];
    logic [5:0]       mon_e;

    clk_div_ctrl #(
        .CNT_W    (c_CNT_W),
        .DIV_INIT (c_DIV0),
        .SETTLE   (c_SETTLE)
    ) u_dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_cfg_req (cfg_req),
        .i_cfg_div (cfg_div),
        .o_cfg_ack (cfg_ack),
        .o_cfg_err (cfg_err),
        .o_clk_en  (clk_en),
        .o_clk_div (clk_div),
        .o_locked  (locked),
        .o_busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("out", 32'({clk_en, clk_div, locked, busy, cfg_ack, cfg_err}), 32'(mon_e));
        end
    end

    // One cycle: drive inputs just after the rising edge, queue what the
    // outputs must show during this cycle.
    task automatic tick(input logic rn, input logic req, input logic [7:0] dv,
                        input logic [5:0] e);
        @(posedge clk);
        #1;
        rst_n   = rn;
        cfg_req = req;
        cfg_div = dv;
        exp_q.push_back(e);
    endtask

    // One counting cycle of the model divider.
    task automatic count_one(input logic req, input logic [7:0] rd, input logic lk,
                             input logic bz, input logic ak, input logic er);
        logic en;
        logic dv;
        en = (m_cnt == m_div - 1);
        dv = (m_cnt < m_div / 2);
        tick(1'b1, req, rd, {en, dv, lk, bz, ak, er});
        m_cnt = (m_cnt + 1) % m_div;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) count_one(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Request cycle, drain to end of period, LOAD cycle.
    task automatic head(input int nd);
        logic last;
        count_one(1'b1, 8'(nd), 1'b1, 1'b0, 1'b0, 1'b0);
        do begin
            last = (m_cnt == m_div - 1);
            count_one(1'b1, 8'(nd), 1'b1, 1'b1, 1'b0, 1'b0);
        end while (!last);
        tick(1'b1, 1'b1, 8'(nd), c_GATED);
    endtask

    // Settle cycles, ack cycle, then the request held for 'hold' more cycles.
    task automatic tail(input int nd, input int hold);
        for (int i = 0; i < c_SETTLE; i++) tick(1'b1, 1'b1, 8'(nd), c_GATED);
        m_div = nd;
        m_cnt = 0;
        count_one(1'b1, 8'(nd), 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < hold; i++) count_one(1'b1, 8'(nd), 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic reject(input logic [7:0] dv);
        count_one(1'b1, dv, 1'b1, 1'b0, 1'b0, 1'b0);
        count_one(1'b1, dv, 1'b1, 1'b0, 1'b1, 1'b1);
        count_one(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b1;
        cfg_req = 1'b0;
        cfg_div = 8'd0;
        #2 rst_n = 1'b0;

        // Reset, then lock after the settle window at DIV_INIT.
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'd0, c_GATED);
        for (int i = 0; i < c_SETTLE; i++) tick(1'b1, 1'b0, 8'd0, c_GATED);
        m_div = c_DIV0;
        m_cnt = 0;
        run_n(6);

        // Reconfigure to 5 from cnt 0 of a div-2 period.
        head(5);
        tail(5, 0);
        run_n(12);

        // Illegal ratios are rejected without disturbing the cadence.
        reject(8'd1);
        run_n(4);
        reject(8'd0);
        run_n(6);

        // Request held three cycles past its ack: one sequence only.
        head(4);
        tail(4, 3);
        run_n(10);

        // Same ratio still runs the full sequence.
        head(4);
        tail(4, 0);
        run_n(8);

        // Reset during the settle of a div-7 change.
        head(7);
        tick(1'b1, 1'b1, 8'd7, c_GATED);
        tick(1'b1, 1'b1, 8'd7, c_GATED);
        tick(1'b0, 1'b0, 8'd0, c_GATED);
        #1;
        chk("rst_async", 32'({clk_en, clk_div, locked, busy, cfg_ack, cfg_err}), 32'(c_GATED));
        tick(1'b0, 1'b0, 8'd0, c_GATED);
        tick(1'b0, 1'b0, 8'd0, c_GATED);
        // Release; a div-3 request raised during settle waits for RUN.
        tick(1'b1, 1'b0, 8'd0, c_GATED);
        tick(1'b1, 1'b0, 8'd0, c_GATED);
        tick(1'b1, 1'b1, 8'd3, c_GATED);
        tick(1'b1, 1'b1, 8'd3, c_GATED);
        m_div = c_DIV0;
        m_cnt = 0;
        head(3);
        tail(3, 0);
        run_n(9);

        // Maximum ratio over more than three periods.
        head(255);
        tail(255, 0);
        run_n(3 * 255 + 3);

        @(negedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
